// File: rtl/risc_ctrl_pkg.sv
// Shared types for the RISC sequence controller: opcodes, phase names, FSM state
// and the bundle of datapath control strobes.
package risc_ctrl_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic halt;
    logic inc_pc;
    logic ld_ac;
    logic wr;
    logic ld_pc;
    logic data_e;
  } ctrl_t;

  // Instructions that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_seq_ctrl_if.sv
// Controller <-> datapath bundle: status/opcode into the controller, phase and
// control strobes out of it.
interface risc_seq_ctrl_if #(
  parameter int OPW = 3
);

  logic           en;
  logic           go;
  logic           mem_rdy;
  logic           zero;
  logic [OPW-1:0] opcode;

  logic [2:0]     phase;
  logic           sel;
  logic           rd;
  logic           ld_ir;
  logic           halt;
  logic           inc_pc;
  logic           ld_ac;
  logic           wr;
  logic           ld_pc;
  logic           data_e;
  logic           illegal;

  modport master (
    input  en, go, mem_rdy, zero, opcode,
    output phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e, illegal
  );

  modport slave (
    output en, go, mem_rdy, zero, opcode,
    input  phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e, illegal
  );

endinterface

// File: rtl/risc_seq_ctrl_phase_counter.sv
// Eight-step phase register: counts on en, synchronous clear back to INST_ADDR,
// wraps STORE -> INST_ADDR.
module phase_counter
  import risc_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   clr,
  output phase_t count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= INST_ADDR;
    end else if (en) begin
      count <= clr ? INST_ADDR : phase_t'(count + 3'd1);
    end
  end

endmodule

// File: rtl/risc_seq_ctrl.sv
// RISC sequence controller: RUN/HALTED FSM, memory-ready stalls and the
// combinational phase/opcode decode that drives the datapath strobes.
module risc_seq_ctrl
  import risc_ctrl_pkg::*;
#(
  parameter int OPW     = 3,
  parameter bit WAIT_EN = 1'b1
) (
  input logic             clk,
  input logic             rst,
  risc_seq_ctrl_if.master bus
);

  state_t         state;
  phase_t         phase;
  ctrl_t          ctl;
  logic [OPW-1:0] opcode;
  logic [5:0]     op_ext;
  logic           illegal_op;
  opcode_t        op;
  logic           run;
  logic           aluop;
  logic           stall;
  logic           hlt_now;
  logic           resume;
  logic           cnt_en;

  // Opcodes wider than three bits are legal only when the upper bits are zero.
  assign opcode     = bus.opcode;
  assign op_ext     = 6'(opcode);
  assign illegal_op = |op_ext[5:3];
  assign op         = opcode_t'(op_ext[2:0]);

  assign run   = (state == RUN);
  assign aluop = !illegal_op && is_aluop(op);

  assign stall = WAIT_EN && !bus.mem_rdy &&
                 ((phase == INST_FETCH) || ((phase == OP_FETCH) && aluop));

  assign hlt_now = run && (phase == OP_ADDR) && !illegal_op && (op == HLT);
  assign resume  = !run && bus.go;

  // Counter holds on stall and on the HLT cycle so HALTED sits at OP_ADDR.
  assign cnt_en = bus.en && ((run && !stall && !hlt_now) || resume);

  phase_counter u_phase (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .clr   (resume),
    .count (phase)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else if (bus.en) begin
      unique case (state)
        RUN:     if (hlt_now) state <= HALTED;
        HALTED:  if (bus.go)  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // NOTE: every field gets a default before the case so no path through this
  // block leaves a control unassigned and infers a latch.
  always_comb begin
    ctl = '0;
    if (!run) begin
      ctl.halt = 1'b1;
    end else begin
      unique case (phase)
        INST_ADDR: begin
          ctl.sel = 1'b1;
        end
        INST_FETCH: begin
          ctl.sel = 1'b1;
          ctl.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          ctl.sel   = 1'b1;
          ctl.rd    = 1'b1;
          ctl.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          ctl.inc_pc = 1'b1;
          ctl.halt   = !illegal_op && (op == HLT);
        end
        OP_FETCH: begin
          ctl.rd = aluop;
        end
        ALU_OP: begin
          ctl.rd     = aluop;
          ctl.inc_pc = !illegal_op && (op == SKZ) && bus.zero;
          ctl.ld_pc  = !illegal_op && (op == JMP);
          ctl.data_e = !illegal_op && (op == STO);
        end
        STORE: begin
          ctl.rd     = aluop;
          ctl.ld_ac  = aluop;
          ctl.ld_pc  = !illegal_op && (op == JMP);
          ctl.wr     = !illegal_op && (op == STO);
          ctl.data_e = !illegal_op && (op == STO);
        end
        default: ctl = '0;
      endcase
    end
  end

  assign bus.phase   = phase;
  assign bus.sel     = ctl.sel;
  assign bus.rd      = ctl.rd;
  assign bus.ld_ir   = ctl.ld_ir;
  assign bus.halt    = ctl.halt;
  assign bus.inc_pc  = ctl.inc_pc;
  assign bus.ld_ac   = ctl.ld_ac;
  assign bus.wr      = ctl.wr;
  assign bus.ld_pc   = ctl.ld_pc;
  assign bus.data_e  = ctl.data_e;
  // Only the execute half of an instruction is flagged; fetch must still run.
  assign bus.illegal = run && phase[2] && illegal_op;

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// Directed bench for risc_seq_ctrl (OPW=4, stalls enabled) with hand-computed
// expected strobe vectors per phase.
module tb_risc_seq_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  risc_seq_ctrl_if #(.OPW(4)) bus ();

  risc_seq_ctrl #(.OPW(4), .WAIT_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e}
  logic [8:0] ctl;
  assign ctl = {bus.sel, bus.rd, bus.ld_ir, bus.halt, bus.inc_pc,
                bus.ld_ac, bus.wr, bus.ld_pc, bus.data_e};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full instruction from ph0; fetch strobes are common to all opcodes.
  task automatic run_seq(string tag, logic [8:0] e4, logic [8:0] e5,
                         logic [8:0] e6, logic [8:0] e7, logic ill);
    logic [8:0] exp [8];
    exp[0] = 9'h100; exp[1] = 9'h180; exp[2] = 9'h1C0; exp[3] = 9'h1C0;
    exp[4] = e4;     exp[5] = e5;     exp[6] = e6;     exp[7] = e7;
    #1;
    for (int p = 0; p < 8; p++) begin
      check($sformatf("%s ph%0d phase", tag, p), 32'(bus.phase), 32'(p));
      check($sformatf("%s ph%0d ctl", tag, p), 32'(ctl), 32'(exp[p]));
      check($sformatf("%s ph%0d illegal", tag, p), 32'(bus.illegal),
            32'((p >= 4) && ill));
      tick();
    end
  endtask

  initial begin
    int   lda_ph  [13] = '{0, 1, 1, 1, 1, 2, 3, 4, 5, 5, 5, 6, 7};
    logic lda_rdy [13] = '{1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1};

    n_checks = 0;
    n_pass   = 0;
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.go      = 1'b0;
    bus.mem_rdy = 1'b1;
    bus.zero    = 1'b0;
    bus.opcode  = 4'd0;
    tick();
    check("reset phase", 32'(bus.phase), 32'd0);
    check("reset ctl", 32'(ctl), 32'h100);
    check("reset illegal", 32'(bus.illegal), 32'd0);
    rst = 1'b0;

    bus.en     = 1'b1;
    bus.opcode = 4'd2;
    run_seq("add", 9'h010, 9'h080, 9'h080, 9'h088, 1'b0);

    bus.opcode = 4'd1;
    bus.zero   = 1'b1;
    run_seq("skz z1", 9'h010, 9'h000, 9'h010, 9'h000, 1'b0);
    bus.zero   = 1'b0;
    run_seq("skz z0", 9'h010, 9'h000, 9'h000, 9'h000, 1'b0);

    bus.opcode = 4'd7;
    run_seq("jmp", 9'h010, 9'h000, 9'h002, 9'h002, 1'b0);
    bus.opcode = 4'd6;
    run_seq("sto", 9'h010, 9'h000, 9'h001, 9'h005, 1'b0);

    bus.opcode = 4'd9;
    run_seq("op9", 9'h010, 9'h000, 9'h000, 9'h000, 1'b1);
    bus.opcode = 4'd2;
    run_seq("add after op9", 9'h010, 9'h080, 9'h080, 9'h088, 1'b0);

    // LDA with 3 stall clocks in ph1 and 2 in ph5: 13 clocks total.
    bus.opcode = 4'd5;
    for (int c = 0; c < 13; c++) begin
      bus.mem_rdy = lda_rdy[c];
      #1;
      check($sformatf("lda c%0d phase", c), 32'(bus.phase), 32'(lda_ph[c]));
      if (!lda_rdy[c])
        check($sformatf("lda c%0d stall ctl", c), 32'(ctl),
              (c < 5) ? 32'h180 : 32'h080);
      tick();
    end
    bus.mem_rdy = 1'b1;
    check("lda done phase", 32'(bus.phase), 32'd0);

    // en=0 freezes RUN regardless of mem_rdy/go.
    bus.opcode = 4'd2;
    tick();
    tick();
    bus.en      = 1'b0;
    bus.mem_rdy = 1'b0;
    bus.go      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("en0 hold %0d", i), 32'(bus.phase), 32'd2);
    end
    bus.en      = 1'b1;
    bus.mem_rdy = 1'b1;
    bus.go      = 1'b0;
    tick();
    check("en1 resume", 32'(bus.phase), 32'd3);
    for (int i = 0; i < 5; i++) tick();
    check("back to ph0", 32'(bus.phase), 32'd0);

    // HLT: go during the ph4 entry cycle is ignored.
    bus.opcode = 4'd0;
    for (int i = 0; i < 4; i++) tick();
    check("hlt ph4 phase", 32'(bus.phase), 32'd4);
    check("hlt ph4 ctl", 32'(ctl), 32'h030);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    check("halted entry phase", 32'(bus.phase), 32'd4);
    check("halted entry ctl", 32'(ctl), 32'h020);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("halted %0d phase", i), 32'(bus.phase), 32'd4);
      check($sformatf("halted %0d ctl", i), 32'(ctl), 32'h020);
    end
    bus.en = 1'b0;
    bus.go = 1'b1;
    tick();
    tick();
    check("halted en0 go", 32'(ctl), 32'h020);
    bus.en = 1'b1;
    tick();
    bus.go = 1'b0;
    check("go phase", 32'(bus.phase), 32'd0);
    check("go ctl", 32'(ctl), 32'h100);

    // Reset while HALTED abandons it.
    for (int i = 0; i < 5; i++) tick();
    check("halted again", 32'(ctl), 32'h020);
    rst = 1'b1;
    #1;
    check("rst halted phase", 32'(bus.phase), 32'd0);
    check("rst halted ctl", 32'(ctl), 32'h100);
    tick();
    rst = 1'b0;
    tick();
    check("after rst halted", 32'(bus.phase), 32'd1);

    // Async reset in ph6 of STO drops wr/data_e at once.
    bus.opcode = 4'd6;
    for (int i = 0; i < 5; i++) tick();
    check("sto ph6 phase", 32'(bus.phase), 32'd6);
    check("sto ph6 ctl", 32'(ctl), 32'h001);
    rst = 1'b1;
    #1;
    check("sto rst phase", 32'(bus.phase), 32'd0);
    check("sto rst ctl", 32'(ctl), 32'h100);
    tick();
    check("sto rst held ctl", 32'(ctl), 32'h100);
    rst = 1'b0;
    tick();
    check("sto rst release", 32'(bus.phase), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/risc_seq_ctrl.md
RISC_SEQ_CTRL -- requirements
Module: risc_seq_ctrl

Interface
REQ-001 Parameter OPW, default 3: opcode width, legal range 3..6.
REQ-002 Parameter WAIT_EN, default 1: 1 enables memory-ready stalls, 0 ignores mem_rdy.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 en  in  1  global advance enable; 0 freezes all state.
REQ-006 go  in  1  resume request, sampled only in HALTED.
REQ-007 mem_rdy  in  1  memory data valid for the current fetch phase.
REQ-008 zero  in  1  accumulator-zero flag.
REQ-009 opcode  in  OPW  current instruction opcode from the IR.
REQ-010 phase  out  3  current phase index 0..7.
REQ-011 sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e  out  1 each  datapath controls.
REQ-012 illegal  out  1  current instruction has an undefined opcode.

Function
REQ-013 Opcode values SHALL be HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7; ALUOP = ADD|AND|XOR|LDA.
REQ-014 Any opcode value >7 (OPW>3) SHALL decode as NOP and assert illegal in phases 4..7.
REQ-015 The FSM SHALL have states RUN (phase counter active) and HALTED.
REQ-016 In RUN with en=1 and no stall, phase SHALL increment by 1 per clock and wrap 7->0.
REQ-017 Stall: with WAIT_EN=1, en=1 and mem_rdy=0, phase SHALL hold in phase 1, and in phase 5 when the opcode is ALUOP; outputs SHALL hold their values.
REQ-018 With en=0, phase and state SHALL hold regardless of mem_rdy or go.
REQ-019 Decode in RUN SHALL be combinational from phase and opcode:
- ph0: sel.
- ph1: sel, rd.
- ph2: sel, rd, ld_ir.
- ph3: sel, rd, ld_ir.
- ph4: inc_pc; halt if HLT.
- ph5: rd if ALUOP.
- ph6: rd if ALUOP; inc_pc if SKZ and zero; ld_pc if JMP; data_e if STO.
- ph7: rd and ld_ac if ALUOP; ld_pc if JMP; wr and data_e if STO.
All unlisted outputs 0.
REQ-020 HLT in ph4 with en=1 SHALL move the FSM to HALTED on the next edge.
REQ-021 In HALTED: halt=1, all other controls 0, phase=4.
REQ-022 In HALTED, go=1 with en=1 SHALL return the FSM to RUN at phase 0 on the next edge.
REQ-023 go outside HALTED SHALL be ignored, including the ph4 cycle that enters HALTED.
REQ-024 rd, wr and ld_ir SHALL never be asserted while illegal=1 except rd/ld_ir in ph1..3 (fetch).

Reset
REQ-025 rst=1 SHALL force state RUN, phase 0 immediately and independent of clk.
REQ-026 Outputs during and after reset: sel=1, all other controls 0, illegal=0, phase=0.
REQ-027 rst asserted mid-stall or in HALTED SHALL abandon it; the first instruction after release starts at ph0.

Structure
REQ-028 Package risc_ctrl_pkg SHALL hold the opcode constants, the phase enumeration (INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE) and the state typedef.
REQ-029 Sub-module phase_counter (3-bit, enable, async reset, wrap) SHALL implement the phase register; decode and the FSM SHALL reside in risc_seq_ctrl.

Verification
REQ-030 Reset then en=1, mem_rdy=1, opcode=ADD for 8 clocks -> phase 0..7 sequence; ld_ac=1 only in ph7; rd=1 in ph1-3 and ph5-7.
REQ-031 opcode=SKZ, zero=1 -> inc_pc=1 in ph4 and ph6; with zero=0 -> inc_pc=1 in ph4 only.
REQ-032 opcode=HLT -> halt=1 in ph4, then HALTED with phase=4 for 10 clocks; go=1 for 1 clock -> phase=0, halt=0.
REQ-033 opcode=LDA, mem_rdy=0 for 3 clocks in ph1 and 2 clocks in ph5 -> phase holds 3 and 2 cycles, and the instruction completes in 13 clocks.
REQ-034 OPW=4, opcode=9 -> illegal=1 in ph4..7; wr, ld_ac and ld_pc stay 0; the next instruction proceeds normally.
REQ-035 rst pulse in ph6 with opcode=STO -> wr and data_e drop immediately; phase=0 and sel=1 during reset.
